// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encoding, port ids and default memory map for the IF/DM memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  typedef logic port_id_t;
  localparam port_id_t PORT_IF = 1'b0;
  localparam port_id_t PORT_DM = 1'b1;

  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_0000;
  localparam int          IM_WORDS_DEF = 2048;
  localparam logic [31:0] DM_BASE_DEF  = 32'h0000_2000;
  localparam int          DM_WORDS_DEF = 1024;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and SRAM-side signals of the memory port arbiter.
// slave: arbiter view; master: core controller/datapath plus memory macro view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 12
);
  logic                  i_if_req;
  logic [ADDR_WIDTH-1:0] i_if_addr;
  logic                  o_if_done;
  logic [DATA_WIDTH-1:0] o_if_rdata;
  logic                  o_if_err;

  logic                  i_dm_req;
  logic                  i_dm_wen;
  logic [ADDR_WIDTH-1:0] i_dm_addr;
  logic [DATA_WIDTH-1:0] i_dm_wdata;
  logic                  o_dm_done;
  logic [DATA_WIDTH-1:0] o_dm_rdata;
  logic                  o_dm_err;

  logic                  o_mem_cen;
  logic                  o_mem_wen;
  logic [MEM_AW-1:0]     o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  logic                  o_busy;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_done, o_if_rdata, o_if_err,
    input  i_dm_req, i_dm_wen, i_dm_addr, i_dm_wdata,
    output o_dm_done, o_dm_rdata, o_dm_err,
    output o_mem_cen, o_mem_wen, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata,
    output o_busy
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_done, o_if_rdata, o_if_err,
    output i_dm_req, i_dm_wen, i_dm_addr, i_dm_wdata,
    input  o_dm_done, o_dm_rdata, o_dm_err,
    input  o_mem_cen, o_mem_wen, o_mem_addr, o_mem_wdata,
    output i_mem_rdata,
    input  o_busy
  );
endinterface

// File: rtl/mem_region_check.sv
// Combinational legality check: word-aligned and inside [BASE, BASE + 4*WORDS).
// Zero latency, no handshake.
module mem_region_check #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
  parameter int                    WORDS      = 1
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_legal
);

  localparam logic [ADDR_WIDTH:0] LO_ADDR = {1'b0, BASE};
  localparam logic [ADDR_WIDTH:0] SPAN    = (ADDR_WIDTH+1)'(WORDS) << 2;

  // One extra bit makes addresses below BASE wrap to >= 2^ADDR_WIDTH, so a single
  // unsigned compare of the offset against the span covers both bounds.
  logic [ADDR_WIDTH:0] offset;

  assign offset  = {1'b0, i_addr} - LO_ADDR;
  assign o_legal = (i_addr[1:0] == 2'b00) && (offset < SPAN);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM port between IF and DM; done after 2+READ_LAT (read), 2 (write) or 1 (illegal) cycles.
// No backpressure: requests are held until done, the losing port simply waits in IDLE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_AW     = 12,
  parameter int                    READ_LAT   = 1,
  parameter logic [ADDR_WIDTH-1:0] IM_BASE    = ADDR_WIDTH'(IM_BASE_DEF),
  parameter int                    IM_WORDS   = IM_WORDS_DEF,
  parameter logic [ADDR_WIDTH-1:0] DM_BASE    = ADDR_WIDTH'(DM_BASE_DEF),
  parameter int                    DM_WORDS   = DM_WORDS_DEF
) (
  input logic                i_clk,
  input logic                i_rst_n,
  mem_port_arbiter_if.slave  bus
);

  arb_state_e            state_q, state_d;
  port_id_t              gnt_q, gnt_d;
  port_id_t              last_gnt_q, last_gnt_d;
  logic [1:0]            lat_cnt_q, lat_cnt_d;

  logic                  if_done_q, if_done_d;
  logic                  if_err_q, if_err_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  dm_done_q, dm_done_d;
  logic                  dm_err_q, dm_err_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

  logic                  mem_cen_q, mem_cen_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [MEM_AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;

  logic                  if_legal, dm_legal;
  port_id_t              arb_gnt;
  logic                  sel_legal;

  mem_region_check #(.ADDR_WIDTH(ADDR_WIDTH), .BASE(IM_BASE), .WORDS(IM_WORDS)) u_if_chk (
    .i_addr  (bus.i_if_addr),
    .o_legal (if_legal)
  );

  mem_region_check #(.ADDR_WIDTH(ADDR_WIDTH), .BASE(DM_BASE), .WORDS(DM_WORDS)) u_dm_chk (
    .i_addr  (bus.i_dm_addr),
    .o_legal (dm_legal)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    lat_cnt_d   = lat_cnt_q;
    if_done_d   = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_done_d   = 1'b0;
    dm_err_d    = 1'b0;
    dm_rdata_d  = dm_rdata_q;
    mem_cen_d   = 1'b0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    arb_gnt = PORT_IF;
    if (bus.i_if_req && bus.i_dm_req) begin
      arb_gnt = (last_gnt_q == PORT_DM) ? PORT_IF : PORT_DM;
    end else if (bus.i_dm_req) begin
      arb_gnt = PORT_DM;
    end
    sel_legal = (arb_gnt == PORT_DM) ? dm_legal : if_legal;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_if_req || bus.i_dm_req) begin
          gnt_d      = arb_gnt;
          last_gnt_d = arb_gnt;
          if (sel_legal) begin
            // The memory-side flops double as the transaction latch for ACCESS.
            state_d   = ST_ACCESS;
            mem_cen_d = 1'b1;
            if (arb_gnt == PORT_DM) begin
              mem_wen_d   = bus.i_dm_wen;
              mem_addr_d  = bus.i_dm_addr[MEM_AW+1:2];
              mem_wdata_d = bus.i_dm_wen ? bus.i_dm_wdata : '0;
            end else begin
              mem_addr_d  = bus.i_if_addr[MEM_AW+1:2];
            end
          end else begin
            state_d = ST_RESP;
            if (arb_gnt == PORT_DM) begin
              dm_done_d = 1'b1;
              dm_err_d  = 1'b1;
            end else begin
              if_done_d = 1'b1;
              if_err_d  = 1'b1;
            end
          end
        end
      end
      ST_ACCESS: begin
        lat_cnt_d = '0;
        if (mem_wen_q) begin
          state_d = ST_RESP;
          if (gnt_q == PORT_DM) dm_done_d = 1'b1;
          else                  if_done_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == 2'(READ_LAT-1)) begin
          state_d = ST_RESP;
          if (gnt_q == PORT_DM) begin
            dm_done_d  = 1'b1;
            dm_rdata_d = bus.i_mem_rdata;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.i_mem_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= PORT_IF;
      last_gnt_q  <= PORT_DM;
      lat_cnt_q   <= '0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_done_q   <= 1'b0;
      dm_err_q    <= 1'b0;
      dm_rdata_q  <= '0;
      mem_cen_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      lat_cnt_q   <= lat_cnt_d;
      if_done_q   <= if_done_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_done_q   <= dm_done_d;
      dm_err_q    <= dm_err_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_cen_q   <= mem_cen_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_if_done   = if_done_q;
  assign bus.o_if_err    = if_err_q;
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_dm_done   = dm_done_q;
  assign bus.o_dm_err    = dm_err_q;
  assign bus.o_dm_rdata  = dm_rdata_q;
  assign bus.o_mem_cen   = mem_cen_q;
  assign bus.o_mem_wen   = mem_wen_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a READ_LAT=1 instance for most scenarios, a READ_LAT=3 instance for latency.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cen_cnt1 = 0;
  int   done_cnt1 = 0;

  localparam logic [31:0] POISON = 32'hBAD0_BAD0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(12)) bus1 ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(12)) bus3 ();

  mem_port_arbiter #(.READ_LAT(1)) u_dut  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
  mem_port_arbiter #(.READ_LAT(3)) u_dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus3));

  // SRAM models: read data is valid only in the cycle READ_LAT after the enable, poison otherwise.
  logic [31:0] mem1 [0:4095];
  logic [31:0] mem3 [0:4095];
  logic [31:0] rd3_s0, rd3_s1;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem1[4]          <= 32'h00A0_0093;
      mem1[2050]       <= 32'h1234_5678;
      bus1.i_mem_rdata <= POISON;
    end else if (bus1.o_mem_cen && bus1.o_mem_wen) begin
      mem1[bus1.o_mem_addr] <= bus1.o_mem_wdata;
      bus1.i_mem_rdata      <= POISON;
    end else if (bus1.o_mem_cen) begin
      bus1.i_mem_rdata <= mem1[bus1.o_mem_addr];
    end else begin
      bus1.i_mem_rdata <= POISON;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      mem3[7] <= 32'hCAFE_F00D;
      rd3_s0  <= POISON;
    end else if (bus3.o_mem_cen && !bus3.o_mem_wen) begin
      rd3_s0  <= mem3[bus3.o_mem_addr];
    end else begin
      rd3_s0  <= POISON;
    end
    rd3_s1           <= rd3_s0;
    bus3.i_mem_rdata <= rd3_s1;
  end

  always @(negedge clk) begin
    if (bus1.o_mem_cen) cen_cnt1 <= cen_cnt1 + 1;
    if (bus1.o_if_done || bus1.o_dm_done) done_cnt1 <= done_cnt1 + 1;
  end

  // Transaction drivers: start in an IDLE cycle, return in the IDLE cycle after done.
  task automatic do_if(input logic [31:0] addr, output int lat, output logic [31:0] rdata, output logic err);
    lat = -1; rdata = '0; err = 1'b0;
    bus1.i_if_addr = addr;
    bus1.i_if_req  = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus1.o_if_done) begin
        lat = n; rdata = bus1.o_if_rdata; err = bus1.o_if_err;
        break;
      end
    end
    bus1.i_if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_dm(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic err);
    lat = -1; rdata = '0; err = 1'b0;
    bus1.i_dm_wen   = wen;
    bus1.i_dm_addr  = addr;
    bus1.i_dm_wdata = wdata;
    bus1.i_dm_req   = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus1.o_dm_done) begin
        lat = n; rdata = bus1.o_dm_rdata; err = bus1.o_dm_err;
        break;
      end
    end
    bus1.i_dm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_both(output int if_n, output int dm_n, output logic [31:0] if_d, output logic [31:0] dm_d);
    if_n = -1; dm_n = -1; if_d = '0; dm_d = '0;
    bus1.i_if_addr = 32'h0000_0010;
    bus1.i_dm_addr = 32'h0000_2008;
    bus1.i_dm_wen  = 1'b0;
    bus1.i_if_req  = 1'b1;
    bus1.i_dm_req  = 1'b1;
    for (int n = 1; n <= 30 && (if_n < 0 || dm_n < 0); n++) begin
      @(negedge clk);
      if (bus1.o_if_done) begin if_n = n; if_d = bus1.o_if_rdata; bus1.i_if_req = 1'b0; end
      if (bus1.o_dm_done) begin dm_n = n; dm_d = bus1.o_dm_rdata; bus1.i_dm_req = 1'b0; end
    end
    bus1.i_if_req = 1'b0;
    bus1.i_dm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [114:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {bus1.o_busy, bus1.o_mem_cen, bus1.o_mem_wen, bus1.o_if_done, bus1.o_if_err, bus1.o_dm_done,
            bus1.o_dm_err, bus1.o_if_rdata, bus1.o_dm_rdata, bus1.o_mem_addr, bus1.o_mem_wdata};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outs got %h exp 0", outs); end
    checks++;
    if ({bus3.o_busy, bus3.o_mem_cen, bus3.o_if_done} !== 3'b000) begin
      errors++; $display("FAIL reset_dut3 got %b exp 000", {bus3.o_busy, bus3.o_mem_cen, bus3.o_if_done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus1.o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", bus1.o_busy); end
  endtask

  task automatic test_round_robin;
    int if_n, dm_n, lat;
    logic [31:0] if_d, dm_d, d;
    logic e;
    run_both(if_n, dm_n, if_d, dm_d);
    checks++;
    if (if_n !== 3) begin errors++; $display("FAIL rr1_if_first got %0d exp 3", if_n); end
    checks++;
    if (dm_n !== 7) begin errors++; $display("FAIL rr1_dm_second got %0d exp 7", dm_n); end
    checks++;
    if (dm_d !== 32'h1234_5678) begin errors++; $display("FAIL rr1_dm_data got %h exp 12345678", dm_d); end
    do_if(32'h0000_0010, lat, d, e);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rr_single_if_lat got %0d exp 3", lat); end
    run_both(if_n, dm_n, if_d, dm_d);
    checks++;
    if (dm_n !== 3) begin errors++; $display("FAIL rr2_dm_first got %0d exp 3", dm_n); end
    checks++;
    if (if_n !== 7) begin errors++; $display("FAIL rr2_if_second got %0d exp 7", if_n); end
    checks++;
    if (if_d !== 32'h00A0_0093) begin errors++; $display("FAIL rr2_if_data got %h exp 00a00093", if_d); end
  endtask

  task automatic test_if_read;
    bus1.i_if_addr = 32'h0000_0010;
    bus1.i_if_req  = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus1.o_mem_cen, bus1.o_mem_wen, bus1.o_mem_addr} !== {1'b1, 1'b0, 12'd4}) begin
      errors++; $display("FAIL if_access got %h exp %h", {bus1.o_mem_cen, bus1.o_mem_wen, bus1.o_mem_addr}, {1'b1, 1'b0, 12'd4});
    end
    checks++;
    if (bus1.o_busy !== 1'b1) begin errors++; $display("FAIL if_busy got %b exp 1", bus1.o_busy); end
    @(negedge clk);
    checks++;
    if ({bus1.o_if_done, bus1.o_mem_cen} !== 2'b00) begin
      errors++; $display("FAIL if_wait got %b exp 00", {bus1.o_if_done, bus1.o_mem_cen});
    end
    @(negedge clk);
    checks++;
    if ({bus1.o_if_done, bus1.o_if_err} !== 2'b10) begin
      errors++; $display("FAIL if_done got %b exp 10", {bus1.o_if_done, bus1.o_if_err});
    end
    checks++;
    if (bus1.o_if_rdata !== 32'h00A0_0093) begin errors++; $display("FAIL if_rdata got %h exp 00a00093", bus1.o_if_rdata); end
    bus1.i_if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus1.o_if_done, bus1.o_if_err, bus1.o_busy} !== 3'b000) begin
      errors++; $display("FAIL if_after got %b exp 000", {bus1.o_if_done, bus1.o_if_err, bus1.o_busy});
    end
    checks++;
    if (bus1.o_if_rdata !== 32'h00A0_0093) begin errors++; $display("FAIL if_rdata_hold got %h exp 00a00093", bus1.o_if_rdata); end
  endtask

  task automatic test_dm_store_load;
    int lat;
    logic [31:0] d;
    logic e;
    bus1.i_dm_wen   = 1'b1;
    bus1.i_dm_addr  = 32'h0000_2004;
    bus1.i_dm_wdata = 32'hDEAD_BEEF;
    bus1.i_dm_req   = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus1.o_mem_cen, bus1.o_mem_wen, bus1.o_mem_addr} !== {1'b1, 1'b1, 12'd2049}) begin
      errors++; $display("FAIL st_access got %h exp %h", {bus1.o_mem_cen, bus1.o_mem_wen, bus1.o_mem_addr}, {1'b1, 1'b1, 12'd2049});
    end
    checks++;
    if (bus1.o_mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_wdata got %h exp deadbeef", bus1.o_mem_wdata); end
    @(negedge clk);
    checks++;
    if ({bus1.o_if_done, bus1.o_dm_done, bus1.o_dm_err} !== 3'b010) begin
      errors++; $display("FAIL st_done got %b exp 010", {bus1.o_if_done, bus1.o_dm_done, bus1.o_dm_err});
    end
    bus1.i_dm_req = 1'b0;
    bus1.i_dm_wen = 1'b0;
    @(negedge clk);
    do_dm(1'b0, 32'h0000_2004, 32'h0, lat, d, e);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL ld_lat got %0d exp 3", lat); end
    checks++;
    if ({e, d} !== {1'b0, 32'hDEAD_BEEF}) begin errors++; $display("FAIL ld_data got %h exp 0deadbeef", {e, d}); end
  endtask

  task automatic test_illegal;
    int lat, c0;
    logic [31:0] d;
    logic e;
    c0 = cen_cnt1;
    do_dm(1'b0, 32'h0000_3000, 32'h0, lat, d, e);
    checks++;
    if ({lat, e} !== {32'd1, 1'b1}) begin errors++; $display("FAIL dm_oor lat/err got %0d/%b exp 1/1", lat, e); end
    checks++;
    if ({bus1.o_dm_done, bus1.o_dm_err} !== 2'b00) begin
      errors++; $display("FAIL dm_err_clear got %b exp 00", {bus1.o_dm_done, bus1.o_dm_err});
    end
    do_if(32'h0000_0002, lat, d, e);
    checks++;
    if ({lat, e} !== {32'd1, 1'b1}) begin errors++; $display("FAIL if_misalign lat/err got %0d/%b exp 1/1", lat, e); end
    do_dm(1'b1, 32'h0000_3000, 32'h55AA_55AA, lat, d, e);
    checks++;
    if ({lat, e} !== {32'd1, 1'b1}) begin errors++; $display("FAIL st_oor lat/err got %0d/%b exp 1/1", lat, e); end
    do_if(32'h0000_2000, lat, d, e);
    checks++;
    if ({lat, e} !== {32'd1, 1'b1}) begin errors++; $display("FAIL if_oor lat/err got %0d/%b exp 1/1", lat, e); end
    do_dm(1'b0, 32'h0000_1FFC, 32'h0, lat, d, e);
    checks++;
    if ({lat, e} !== {32'd1, 1'b1}) begin errors++; $display("FAIL dm_below lat/err got %0d/%b exp 1/1", lat, e); end
    checks++;
    if (cen_cnt1 !== c0) begin errors++; $display("FAIL illegal_cen got %0d exp %0d", cen_cnt1, c0); end
    do_dm(1'b0, DM_BASE_DEF + 32'(4 * DM_WORDS_DEF) - 32'd4, 32'h0, lat, d, e);
    checks++;
    if ({lat, e} !== {32'd3, 1'b0}) begin errors++; $display("FAIL dm_top lat/err got %0d/%b exp 3/0", lat, e); end
    do_if(32'h0000_1FFC, lat, d, e);
    checks++;
    if ({lat, e} !== {32'd3, 1'b0}) begin errors++; $display("FAIL if_top lat/err got %0d/%b exp 3/0", lat, e); end
  endtask

  task automatic test_read_lat3;
    bus3.i_if_addr = 32'h0000_001C;
    bus3.i_if_req  = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      checks++;
      if (bus3.o_busy !== 1'b1) begin errors++; $display("FAIL l3_busy_%0d got %b exp 1", n, bus3.o_busy); end
      checks++;
      if ({bus3.o_mem_cen, bus3.o_if_done} !== {n == 1, n == 5}) begin
        errors++; $display("FAIL l3_cen_done_%0d got %b exp %b", n, {bus3.o_mem_cen, bus3.o_if_done}, {n == 1, n == 5});
      end
    end
    checks++;
    if ({bus3.o_if_err, bus3.o_if_rdata} !== {1'b0, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL l3_rdata got %h exp 0cafef00d", {bus3.o_if_err, bus3.o_if_rdata});
    end
    bus3.i_if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus3.o_busy, bus3.o_if_done} !== 2'b00) begin
      errors++; $display("FAIL l3_after got %b exp 00", {bus3.o_busy, bus3.o_if_done});
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [114:0] outs;
    int lat, d0;
    logic [31:0] d;
    logic e;
    d0 = done_cnt1;
    bus1.i_if_addr = 32'h0000_0010;
    bus1.i_if_req  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus1.o_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", bus1.o_busy); end
    rst_n = 1'b0;
    #1;
    outs = {bus1.o_busy, bus1.o_mem_cen, bus1.o_mem_wen, bus1.o_if_done, bus1.o_if_err, bus1.o_dm_done,
            bus1.o_dm_err, bus1.o_if_rdata, bus1.o_dm_rdata, bus1.o_mem_addr, bus1.o_mem_wdata};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL mid_reset_outs got %h exp 0", outs); end
    bus1.i_if_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt1 !== d0) begin errors++; $display("FAIL mid_no_done got %0d exp %0d", done_cnt1, d0); end
    do_if(32'h0000_0010, lat, d, e);
    checks++;
    if ({lat, e} !== {32'd3, 1'b0}) begin errors++; $display("FAIL post_rst lat/err got %0d/%b exp 3/0", lat, e); end
    checks++;
    if (d !== 32'h00A0_0093) begin errors++; $display("FAIL post_rst_data got %h exp 00a00093", d); end
  endtask

  initial begin
    bus1.i_if_req = 1'b0; bus1.i_if_addr = '0;
    bus1.i_dm_req = 1'b0; bus1.i_dm_wen = 1'b0; bus1.i_dm_addr = '0; bus1.i_dm_wdata = '0;
    bus3.i_if_req = 1'b0; bus3.i_if_addr = '0;
    bus3.i_dm_req = 1'b0; bus3.i_dm_wen = 1'b0; bus3.i_dm_addr = '0; bus3.i_dm_wdata = '0;
    test_reset;
    test_round_robin;
    test_if_read;
    test_dm_store_load;
    test_illegal;
    test_read_lat3;
    test_reset_mid_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data SRAM between two requesters: the instruction-fetch port (IF) and the load/store data port (DM).
- Sequences each access: arbitration, one-cycle memory enable, read-latency wait, and registered response.
- Checks address range and alignment per port, so out-of-range accesses return an error instead of touching memory.
- Sits between the core controller/datapath and the memory macro, replacing the IM/DM address mux.

Parameters:
- ADDR_WIDTH, 32, byte address width of the requester ports
- DATA_WIDTH, 32, data word width
- MEM_AW, 12, memory word-address width (o_mem_addr)
- READ_LAT, 1, cycles from the o_mem_cen cycle to valid i_mem_rdata (legal 1..3)
- IM_BASE, 32'h0000_0000, IF region base byte address
- IM_WORDS, 2048, IF region size in words
- DM_BASE, 32'h0000_2000, DM region base byte address
- DM_WORDS, 1024, DM region size in words

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_if_req  in  1  IF read request; held until o_if_done
- i_if_addr  in  ADDR_WIDTH  IF byte address
- o_if_done  out  1  one-cycle IF completion pulse
- o_if_rdata  out  DATA_WIDTH  IF read data, valid with o_if_done
- o_if_err  out  1  IF error, valid with o_if_done
- i_dm_req  in  1  DM request; held until o_dm_done
- i_dm_wen  in  1  0: load, 1: store
- i_dm_addr  in  ADDR_WIDTH  DM byte address
- i_dm_wdata  in  DATA_WIDTH  store data
- o_dm_done  out  1  one-cycle DM completion pulse
- o_dm_rdata  out  DATA_WIDTH  load data, valid with o_dm_done
- o_dm_err  out  1  DM error, valid with o_dm_done
- o_mem_cen  out  1  memory access enable
- o_mem_wen  out  1  memory write enable (only with o_mem_cen)
- o_mem_addr  out  MEM_AW  memory word address
- o_mem_wdata  out  DATA_WIDTH  memory write data
- i_mem_rdata  in  DATA_WIDTH  memory read data
- o_busy  out  1  state != IDLE

Behaviour:
- Reset: i_rst_n is asynchronous, active-low. State returns to IDLE, last_gnt=DM, and every output is 0. Reset mid-transaction abandons the access; no done pulse is issued.
- States and transitions:
  - IDLE -> ACCESS when a granted request is legal.
  - IDLE -> RESP when the granted request is illegal.
  - ACCESS -> WAIT when it is a read; ACCESS -> RESP when it is a write.
  - WAIT -> RESP after READ_LAT cycles.
  - RESP -> IDLE always.
- Arbitration happens in IDLE only. With a single request, that requester is granted. With both requesting, the port other than last_gnt is granted (round-robin), and last_gnt updates on each grant. At reset IF wins the first tie.
- Latch: at grant, the port id, address, wen and wdata are registered. Requester inputs are ignored until RESP.
- Legality: address[1:0]==0 and base <= addr < base+4*WORDS for the port's region. IF is always a read.
- Memory word address: addr[MEM_AW+1:2].
- ACCESS: o_mem_cen=1 for exactly one cycle, driving o_mem_wen/addr/wdata from the latched values. Memory outputs are 0 in all other states.
- Read data: i_mem_rdata is captured at the end of the cycle READ_LAT cycles after ACCESS, into the granted port's rdata register.
- RESP: the granted port's done pulses for one cycle with err/rdata. rdata holds until the next capture. err clears when done drops.
- Latency from a request seen in IDLE at cycle t:
  - legal read: done at t+2+READ_LAT
  - write: done at t+2
  - illegal: done at t+1
- Requester protocol: the request is deasserted in the cycle after done. If a request drops early, the latched transaction still completes and done still pulses.
- The non-granted port simply waits and sees no signal. There is at least one IDLE cycle between transactions.
- An illegal store never asserts o_mem_cen or o_mem_wen.

Decomposition:
- Shared package define file: state encoding (IDLE=0, ACCESS=1, WAIT=2, RESP=3), the port-id constants PORT_IF/PORT_DM, and the default region base/size constants, so the controller and testbench use the same memory map.
- One sub-module, mem_region_check: combinational address/alignment legality check, instantiated once per port.

Test Plan:
- IF read 0x0000_0010, READ_LAT=1, memory word 4 = 0x00A00093 -> o_mem_cen at t+1 with addr 4, wen 0; o_if_done at t+3 with rdata 0x00A00093, err 0.
- DM store 0x0000_2004 with data 0xDEADBEEF -> cen+wen at t+1, addr 2049, wdata 0xDEADBEEF; o_dm_done at t+2. A following DM load of 0x2004 returns 0xDEADBEEF.
- Simultaneous IF and DM requests after reset -> IF served first, then DM. Repeat with both requesting again -> DM served first (round-robin).
- DM load 0x0000_3000 (out of range) and IF fetch 0x0000_0002 (misaligned) -> done at t+1 with err=1, o_mem_cen never asserted.
- READ_LAT=3 build, IF read of word 7 -> done at t+5 with correct data. o_busy high from t+1 to t+5.
- Reset asserted during WAIT -> all outputs 0 immediately, no done pulse; after release, a new IF read completes normally.
